// File: rtl/btn_pulse_sync.sv
// Button input stage: 2-FF sync, per-button debounce, and a release-locked press FSM
// that emits one-cycle press pulses. Optional auto-repeat is enabled by BTN_AUTOREPEAT_EN.
module btn_pulse_sync #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W           = 22,
  parameter int REPEAT_DELAY    = 3125000,
  parameter int REPEAT_PERIOD   = 625000
) (
  input  logic       clk_6p25,
  input  logic       rst_n,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic       pulse_l,
  output logic       pulse_r,
  output logic       pulse_c,
  output logic [2:0] btn_held,
  output logic       armed
);

  // Counters must be able to hold every terminal count they compare against.
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > (1 << CNT_W)) ||
      (REPEAT_DELAY < 1) || (REPEAT_DELAY > (1 << CNT_W)) ||
      (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > (1 << CNT_W))) begin : g_cfg_error
    $error("btn_pulse_sync: CNT_W too small or cycle parameter out of range");
  end

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [2:0]            raw_s;
  logic [2:0]            sync1_r;
  logic [2:0]            sync2_r;
  logic [2:0]            held_r;
  logic [2:0]            held_nxt_s;
  logic [2:0][CNT_W-1:0] db_cnt_r;
  logic [2:0][CNT_W-1:0] db_cnt_nxt_s;
  logic [CNT_W-1:0]      rel_cnt_r;
  logic [CNT_W-1:0]      rel_cnt_nxt_s;
  logic                  all_low_s;
  logic                  rel_done_s;
  logic [2:0]            rise_s;
  logic [2:0]            win_s;
  logic [2:0]            win_r;
  logic [2:0]            win_nxt_s;
  logic [2:0]            pulse_vec_r;
  logic [2:0]            pulse_nxt_s;
  logic                  armed_r;
  state_t                state_r;
  state_t                state_nxt_s;
`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0]      rep_cnt_r;
  logic [CNT_W-1:0]      rep_cnt_nxt_s;
  logic                  rep_first_r;
  logic                  rep_first_nxt_s;
  logic                  rep_dead_r;
  logic                  rep_dead_nxt_s;
  logic [CNT_W-1:0]      rep_thr_s;
`endif

  assign raw_s = {btnC, btnR, btnL};

  // Per-button debounce: flip the held level after DEBOUNCE_CYCLES of persistent mismatch.
  always_comb begin
    held_nxt_s   = held_r;
    db_cnt_nxt_s = db_cnt_r;
    for (int i = 0; i < 3; i++) begin
      if (sync2_r[i] != held_r[i]) begin
        if (db_cnt_r[i] == DB_MAX) begin
          held_nxt_s[i]   = ~held_r[i];
          db_cnt_nxt_s[i] = '0;
        end else begin
          db_cnt_nxt_s[i] = db_cnt_r[i] + CNT_W'(1);
        end
      end else begin
        db_cnt_nxt_s[i] = '0;
      end
    end
  end

  // Release counter (saturating) and L > R > C winner selection among new debounced rises.
  always_comb begin
    all_low_s  = (sync2_r == 3'b000);
    rel_done_s = all_low_s && (rel_cnt_r == DB_MAX);
    if (!all_low_s) begin
      rel_cnt_nxt_s = '0;
    end else if (rel_cnt_r == DB_MAX) begin
      rel_cnt_nxt_s = rel_cnt_r;
    end else begin
      rel_cnt_nxt_s = rel_cnt_r + CNT_W'(1);
    end
    rise_s = held_nxt_s & ~held_r;
    if (rise_s[0]) begin
      win_s = 3'b001;
    end else if (rise_s[1]) begin
      win_s = 3'b010;
    end else if (rise_s[2]) begin
      win_s = 3'b100;
    end else begin
      win_s = 3'b000;
    end
  end

  // Press FSM next state, pulse request and optional auto-repeat.
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = 3'b000;
    win_nxt_s   = win_r;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_nxt_s   = rep_cnt_r;
    rep_first_nxt_s = rep_first_r;
    rep_dead_nxt_s  = rep_dead_r;
    rep_thr_s       = rep_first_r ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
`endif
    case (state_r)
      ST_IDLE: begin
        if (rel_done_s) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (rise_s != 3'b000) begin
          state_nxt_s = ST_LOCKED;
          pulse_nxt_s = win_s;
          win_nxt_s   = win_s;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_nxt_s   = '0;
          rep_first_nxt_s = 1'b1;
          rep_dead_nxt_s  = 1'b0;
`endif
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_LOCKED: begin
        if (held_r == 3'b000) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
`ifdef BTN_AUTOREPEAT_EN
        // Repeat only while the winner alone stays held; any disturbance kills it for this press.
        if (!rep_dead_r && (held_r == win_r) && (held_nxt_s == win_r)) begin
          if (rep_cnt_r == rep_thr_s) begin
            pulse_nxt_s     = win_r;
            rep_cnt_nxt_s   = '0;
            rep_first_nxt_s = 1'b0;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + CNT_W'(1);
          end
        end else begin
          rep_cnt_nxt_s  = '0;
          rep_dead_nxt_s = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_6p25) begin
    if (!rst_n) begin
      sync1_r     <= 3'b000;
      sync2_r     <= 3'b000;
      held_r      <= 3'b000;
      db_cnt_r    <= '0;
      rel_cnt_r   <= '0;
      win_r       <= 3'b000;
      pulse_vec_r <= 3'b000;
      armed_r     <= 1'b0;
      state_r     <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_r   <= '0;
      rep_first_r <= 1'b0;
      rep_dead_r  <= 1'b0;
`endif
    end else begin
      sync1_r     <= raw_s;
      sync2_r     <= sync1_r;
      held_r      <= held_nxt_s;
      db_cnt_r    <= db_cnt_nxt_s;
      rel_cnt_r   <= rel_cnt_nxt_s;
      win_r       <= win_nxt_s;
      pulse_vec_r <= pulse_nxt_s;
      armed_r     <= (state_nxt_s == ST_ARMED);
      state_r     <= state_nxt_s;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_r   <= rep_cnt_nxt_s;
      rep_first_r <= rep_first_nxt_s;
      rep_dead_r  <= rep_dead_nxt_s;
`endif
    end
  end

  assign pulse_l  = pulse_vec_r[0];
  assign pulse_r  = pulse_vec_r[1];
  assign pulse_c  = pulse_vec_r[2];
  assign btn_held = held_r;
  assign armed    = armed_r;

endmodule

// File: tb/tb_btn_pulse_sync.sv
// Directed self-checking bench for btn_pulse_sync (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, CNT_W=8); auto-repeat scenario runs when BTN_AUTOREPEAT_EN is defined.
module tb_btn_pulse_sync;

  logic       clk_6p25 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btnL     = 1'b0;
  logic       btnR     = 1'b0;
  logic       btnC     = 1'b0;
  logic       pulse_l;
  logic       pulse_r;
  logic       pulse_c;
  logic [2:0] btn_held;
  logic       armed;

  int tests_run = 0;
  int fails     = 0;

  btn_pulse_sync #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_6p25(clk_6p25),
    .rst_n   (rst_n),
    .btnL    (btnL),
    .btnR    (btnR),
    .btnC    (btnC),
    .pulse_l (pulse_l),
    .pulse_r (pulse_r),
    .pulse_c (pulse_c),
    .btn_held(btn_held),
    .armed   (armed)
  );

  always #5 clk_6p25 = ~clk_6p25;

  task automatic step();
    @(posedge clk_6p25);
    #1;
  endtask

  task automatic run_count(input int n, output int cl, output int cr, output int cc);
    cl = 0; cr = 0; cc = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cl += int'(pulse_l);
      cr += int'(pulse_r);
      cc += int'(pulse_c);
    end
  endtask

  task automatic wait_armed(output bit ok);
    int k = 0;
    while (armed !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    ok = (armed === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({pulse_l, pulse_r, pulse_c, btn_held, armed} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000000", {pulse_l, pulse_r, pulse_c, btn_held, armed});
    end
    rst_n = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({pulse_l, pulse_r, pulse_c, btn_held, armed} !== 7'b0) begin
      fails++;
      $display("FAIL reset_early: got %b expected 0000000", {pulse_l, pulse_r, pulse_c, btn_held, armed});
    end
    step();
    tests_run++;
    if (armed !== 1'b1) begin
      fails++;
      $display("FAIL reset_armed: armed=%b expected 1 after 4 low cycles", armed);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    btnL = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (pulse_l !== (k == 6)) begin
        fails++;
        $display("FAIL single_pulse_l cycle %0d: got %b expected %b", k, pulse_l, (k == 6));
      end
      if (k == 6) begin
        tests_run++;
        if ({btn_held, armed, pulse_r, pulse_c} !== 6'b001_000) begin
          fails++;
          $display("FAIL single_state: held/armed/r/c=%b expected 001000", {btn_held, armed, pulse_r, pulse_c});
        end
      end
    end
    btnL = 1'b0;
    wait_armed(ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL single_rearm: armed=%b expected 1", armed);
    end
  endtask

  task automatic test_glitch();
    btnR = 1'b1;
    step();
    step();
    btnR = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if ({pulse_l, pulse_r, pulse_c, btn_held, armed} !== 7'b000_000_1) begin
        fails++;
        $display("FAIL glitch cycle %0d: got %b expected 0000001", k, {pulse_l, pulse_r, pulse_c, btn_held, armed});
      end
    end
  endtask

  task automatic test_simultaneous();
    int cl, cr, cc;
    bit ok;
    btnL = 1'b1;
    btnC = 1'b1;
    run_count(9, cl, cr, cc);
    tests_run++;
    if (cl != 1 || cr != 0 || cc != 0 || btn_held !== 3'b101) begin
      fails++;
      $display("FAIL simul_lc: l=%0d r=%0d c=%0d held=%b expected 1 0 0 101", cl, cr, cc, btn_held);
    end
    btnL = 1'b0;
    btnC = 1'b0;
    wait_armed(ok);
    btnC = 1'b1;
    run_count(9, cl, cr, cc);
    tests_run++;
    if (!ok || cl != 0 || cr != 0 || cc != 1) begin
      fails++;
      $display("FAIL simul_repress_c: armed_ok=%0d l=%0d r=%0d c=%0d expected 1 0 0 1", ok, cl, cr, cc);
    end
    btnC = 1'b0;
    wait_armed(ok);
  endtask

  task automatic test_locked_press();
    int cl, cr, cc;
    bit ok;
    btnR = 1'b1;
    run_count(8, cl, cr, cc);
    tests_run++;
    if (cl != 0 || cr != 1 || cc != 0) begin
      fails++;
      $display("FAIL locked_first_r: l=%0d r=%0d c=%0d expected 0 1 0", cl, cr, cc);
    end
    btnC = 1'b1;
    run_count(10, cl, cr, cc);
    tests_run++;
    if (cl != 0 || cr != 0 || cc != 0 || btn_held !== 3'b110) begin
      fails++;
      $display("FAIL locked_no_c: l=%0d r=%0d c=%0d held=%b expected 0 0 0 110", cl, cr, cc, btn_held);
    end
    btnR = 1'b0;
    btnC = 1'b0;
    wait_armed(ok);
    tests_run++;
    if (!ok || btn_held !== 3'b000) begin
      fails++;
      $display("FAIL locked_rearm: armed=%b held=%b expected 1 000", armed, btn_held);
    end
  endtask

  task automatic test_held_through_reset();
    int cl, cr, cc;
    bit ok;
    btnR  = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    run_count(15, cl, cr, cc);
    tests_run++;
    if (cl != 0 || cr != 0 || cc != 0 || btn_held !== 3'b010 || armed !== 1'b0) begin
      fails++;
      $display("FAIL held_reset: l=%0d r=%0d c=%0d held=%b armed=%b expected 0 0 0 010 0", cl, cr, cc, btn_held, armed);
    end
    btnR = 1'b0;
    wait_armed(ok);
    btnR = 1'b1;
    run_count(9, cl, cr, cc);
    tests_run++;
    if (!ok || cl != 0 || cr != 1 || cc != 0) begin
      fails++;
      $display("FAIL held_reset_repress: armed_ok=%0d l=%0d r=%0d c=%0d expected 1 0 1 0", ok, cl, cr, cc);
    end
    btnR = 1'b0;
    wait_armed(ok);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int cl, cr, cc;
    int k;
    bit exp_c;
    btnC = 1'b1;
    k = 0;
    while (pulse_c !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    tests_run++;
    if (pulse_c !== 1'b1) begin
      fails++;
      $display("FAIL repeat_first: pulse_c=%b expected 1 within 20 cycles", pulse_c);
    end
    for (int n = 1; n <= 30; n++) begin
      step();
      exp_c = (n >= 10) && (((n - 10) % 3) == 0);
      tests_run++;
      if ({pulse_l, pulse_r, pulse_c} !== {2'b00, exp_c}) begin
        fails++;
        $display("FAIL repeat_offset %0d: l/r/c=%b expected 00%b", n, {pulse_l, pulse_r, pulse_c}, exp_c);
      end
    end
    btnC = 1'b0;
    repeat (8) step();
    run_count(15, cl, cr, cc);
    tests_run++;
    if (cl != 0 || cr != 0 || cc != 0 || btn_held !== 3'b000) begin
      fails++;
      $display("FAIL repeat_release: l=%0d r=%0d c=%0d held=%b expected 0 0 0 000", cl, cr, cc, btn_held);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_locked_press();
    test_held_through_reset();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
